// File: rtl/rom_arb_pkg.sv
// rtl/rom_arb_pkg.sv - shared encodings for the instruction-ROM port arbiter
package rom_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STROBE = 1'b1
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LD = 1'b1
  } own_t;

  // grant vector bit positions
  localparam int GNT_IF = 0;
  localparam int GNT_LD = 1;

endpackage

// File: rtl/rom_arb_pick.sv
// rtl/rom_arb_pick.sv - combinational 2-way fetch/load picker
// Optional: ROM_ARB_FIXED_PRIO_EN makes fetch always win a tie.
module rom_arb_pick
  import rom_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       ld_req,
  input  own_t       last,
  output logic [1:0] gnt,
  output own_t       win
);

`ifdef ROM_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = last;
`endif

  always_comb begin
    win = OWN_IF;
    if (if_req && ld_req) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      win = OWN_IF;
`else
      // round-robin: the requester that did not win last time goes first
      win = (last == OWN_IF) ? OWN_LD : OWN_IF;
`endif
    end else if (ld_req) begin
      win = OWN_LD;
    end

    gnt = 2'b00;
    if (if_req || ld_req) begin
      if (win == OWN_LD) gnt[GNT_LD] = 1'b1;
      else               gnt[GNT_IF] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// rtl/rom_port_arbiter.sv - shares the single-port instruction ROM between fetch and loads
// Optional: ROM_ARB_FIXED_PRIO_EN selects fixed fetch-first priority.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [DW-1:0] rom_data
);

  state_t     state;
  own_t       owner;
  own_t       last;
  own_t       win;
  logic [1:0] gnt;
  logic       idle;

  assign idle = (state == ST_IDLE);

  // requests are masked outside IDLE so no grant can leak during the strobe
  rom_arb_pick u_pick (
    .if_req (if_req & idle),
    .ld_req (ld_req & idle),
    .last   (last),
    .gnt    (gnt),
    .win    (win)
  );

  assign if_gnt = gnt[GNT_IF];
  assign ld_gnt = gnt[GNT_LD];

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign last = OWN_LD;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= OWN_LD;
    end else if (idle && (gnt != 2'b00)) begin
      last <= win;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      rom_addr  <= '0;
      rom_cs    <= 1'b0;
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      if_rdata  <= '0;
      ld_rdata  <= '0;
    end else begin
      if_rvalid <= 1'b0;
      ld_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt != 2'b00) begin
            rom_addr <= (win == OWN_LD) ? ld_addr : if_addr;
            owner    <= win;
            rom_cs   <= 1'b1;
            state    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          // ROM word settled after the strobe edge; hand it to the owner
          if (owner == OWN_LD) begin
            ld_rdata  <= rom_data;
            ld_rvalid <= 1'b1;
          end else begin
            if_rdata  <= rom_data;
            if_rvalid <= 1'b1;
          end
          rom_cs <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          rom_cs <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rom_port_arbiter.md
# rom_port_arbiter

Two-requester controller for the single-port instruction ROM of the RISC-V core. It shares the ROM between instruction fetch and data loads (`lw` from code space, as the rv32ui tests require), generating the address and the chip-select strobe the ROM samples on its rising edge, and capturing the read word. It sits between the fetch and load/store units and the ROM's `addr`/`CS`/`out` pins.

## Interface
Parameters:
- `AW`, 32: address width (byte address, passed to the ROM unchanged)
- `DW`, 32: data width

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_gnt`
- `if_addr`  in  AW  fetch byte address
- `if_gnt`  out  1  fetch request accepted this cycle
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid
- `if_rdata`  out  DW  fetch read data
- `ld_req`  in  1  load request; held until `ld_gnt`
- `ld_addr`  in  AW  load byte address
- `ld_gnt`  out  1  load request accepted this cycle
- `ld_rvalid`  out  1  one-cycle pulse: `ld_rdata` valid
- `ld_rdata`  out  DW  load read data
- `rom_addr`  out  AW  ROM address, registered
- `rom_cs`  out  1  ROM strobe, registered; ROM samples on its rising edge
- `rom_data`  in  DW  ROM read word

## Operation
- FSM states: IDLE, STROBE.
- IDLE: if any `*_req` is high, pick a winner. `*_gnt` for the winner is combinational and asserted this cycle. At the clock edge, `rom_addr` is loaded with the winner's address, the owner is recorded, `rom_cs` is set to 1, and the FSM goes to STROBE. With no request, `rom_cs` stays 0 and `rom_addr` holds.
- STROBE: `rom_cs` is 1 and no grants are issued. At the edge, `rom_data` is captured into the owner's `*_rdata`, that requester's `*_rvalid` is set for one cycle, `rom_cs` is cleared, and the FSM returns to IDLE.
- Arbitration is round-robin over two requesters. The last-winner register resets to "load", so fetch wins the first tie. A lone requester always wins.
- `*_rdata` holds its last value until that requester's next `*_rvalid`.
- A request that drops before it is granted has no effect. Request signals are ignored in STROBE.

## Timing
- Reset values: `if_gnt`/`ld_gnt` = 0 (FSM is in IDLE with no request), `if_rvalid`/`ld_rvalid` = 0, `if_rdata`/`ld_rdata` = 0, `rom_addr` = 0, `rom_cs` = 0, state = IDLE, last-winner = load.
- Cycle 0: `*_req` is high in IDLE and `*_gnt` is high.
- Cycle 1: STROBE. `rom_cs` is 1; `rom_data` settles after the `rom_cs` rising edge.
- Cycle 2: `*_rvalid` is 1 with data, and `rom_cs` is 0. The FSM is back in IDLE and can grant again in this same cycle.
- Latency is 2 cycles from grant to data. Peak throughput is one access per 2 cycles.
- `rom_cs` is guaranteed low for at least one cycle between accesses, so every access produces a fresh rising edge.
- Simultaneous requests: exactly one grant per IDLE cycle; the loser keeps its request and is granted in cycle 2.
- Reset mid-access (in STROBE): `rom_cs` and `*_rvalid` go low immediately and the FSM goes to IDLE. The access is lost and the requester must re-request.

## Configuration
- `ROM_ARB_FIXED_PRIO_EN`
  - Defined: fetch always wins over load. The last-winner register is removed.
  - Undefined: round-robin as described above.
  - Latency and handshake are identical in both cases.

## Structure
- Package `rom_arb_pkg` contains:
  - state encoding: `ST_IDLE` = 1'b0, `ST_STROBE` = 1'b1
  - owner encoding: `OWN_IF` = 1'b0, `OWN_LD` = 1'b1
- One sub-module, `rom_arb_pick`: combinational 2-way picker. Inputs are both requests and the last winner; outputs are the grant vector and the winner index. The fixed-priority macro is applied inside it.

## Test plan
- Reset, then `if_req`=1 with `if_addr`=0x10 and ROM word 0x00ff07b7 at that address → `if_gnt` in cycle 0, `rom_cs`=1 in cycle 1, `if_rvalid`=1 with `if_rdata`=0x00ff07b7 in cycle 2.
- `if_req` and `ld_req` both held from reset with addresses 0x0 and 0x20 → grants alternate IF, LD, IF, LD every 2 cycles. With `ROM_ARB_FIXED_PRIO_EN` defined, only IF is granted.
- Back-to-back fetches at 0x0, 0x4, 0x8, 0xc → `rom_cs` toggles 1,0,1,0,… and four rvalids arrive at cycles 2, 4, 6, 8 with words 0x00000093, 0x00000113, 0x00000193, 0x00200193.
- `reset` asserted during STROBE → `rom_cs`=0 and `*_rvalid`=0 immediately, with no rvalid afterwards. A re-request completes normally.
- `ld_req` pulsed for one cycle while an IF access is in STROBE → no `ld_gnt`, no `ld_rvalid`, and `ld_rdata` unchanged.
